async_to_sync_ctrl: RTL

- Receive-side counterpart of the sync-to-async bridge.
- Accepts a randomly timed 4-phase asynchronous req/ack transfer with bundled data and presents each word on a synchronous valid/ready interface in the local clock domain.
- async_req is synchronised through SYNC_STAGE flops. Data is captured once req is seen high. async_ack is returned only after the synchronous consumer has taken the word.

---
 rtl/async_to_sync_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/async_to_sync_ctrl.sv
// async_to_sync_ctrl
// Receive side of a 4-phase req/ack bundled-data bridge. Each word arrives
// on async_req/async_d, asynchronous to clock. The block presents it on a
// synchronous valid/ready interface and returns async_ack only after the
// local consumer has taken it.
//
// async_req passes through SYNC_STAGE flops (legal range 1..4). The FSM acts
// on the level of the last flop (req_s), not on an edge. A new request can
// therefore never alias the previous one: ack only falls once req_s is low,
// and the sender only raises req again after it sees ack low.
//
// Optional feature: define ASYNC_TO_SYNC_TIMEOUT_EN to add the TIMEOUT_CYCLES
// parameter and a sticky timeout_err output. timeout_err flags a sender that
// holds req high for too long after ack. The default build omits both.

module async_to_sync_ctrl #(
    parameter int DATA_WIDTH     = 8,
    parameter int SYNC_STAGE     = 2
`ifdef ASYNC_TO_SYNC_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  async_req,
    output logic                  async_ack,
    input  logic [DATA_WIDTH-1:0] async_d,
    output logic                  sync_valid,
    input  logic                  sync_ready,
    output logic [DATA_WIDTH-1:0] sync_d
`ifdef ASYNC_TO_SYNC_TIMEOUT_EN
    ,
    output logic                  timeout_err
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_VALID = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    state_t                state_q;
    logic                  ack_q;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  req_s;

    // ------------------------------------------------------------------
    // Request synchroniser: one flop per stage. Stage 0 samples the raw
    // asynchronous input, and each later stage samples the one before it.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < SYNC_STAGE; gi++) begin : g_sync
        logic stage_q;
        logic stage_d;

        if (gi == 0) begin : g_first
            assign stage_d = async_req;
        end else begin : g_chain
            assign stage_d = g_sync[gi-1].stage_q;
        end

        // Shift the request level one stage toward the local domain.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                stage_q <= 1'b0;
            end else begin
                stage_q <= stage_d;
            end
        end
    end

    assign req_s = g_sync[SYNC_STAGE-1].stage_q;

    // ------------------------------------------------------------------
    // Handshake FSM. All outputs come straight from flops, so async_ack is
    // glitch-free toward the remote domain.
    // IDLE : wait for req_s high, then capture async_d.
    //        async_d is guaranteed stable here: the sender holds it from
    //        req rise until it sees ack rise.
    // VALID: hold the word until the consumer takes it.
    // ACK  : raise ack and wait for the request to be withdrawn.
    // ------------------------------------------------------------------
    // Advance the handshake and update the registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_s) begin
                        data_q  <= async_d;
                        valid_q <= 1'b1;
                        state_q <= ST_VALID;
                    end
                end
                ST_VALID: begin
                    // No timeout here: a stalled consumer simply stalls the sender.
                    if (sync_ready) begin
                        valid_q <= 1'b0;
                        ack_q   <= 1'b1;
                        state_q <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    if (!req_s) begin
                        ack_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    // Recover from an unreachable encoding into a clean idle state.
                    ack_q   <= 1'b0;
                    valid_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign async_ack  = ack_q;
    assign sync_valid = valid_q;
    assign sync_d     = data_q;

`ifdef ASYNC_TO_SYNC_TIMEOUT_EN
    // ------------------------------------------------------------------
    // ACK-phase watchdog. The counter restarts on every entry to ACK and
    // saturates at TIMEOUT_CYCLES-1. Once it is saturated and req_s is
    // still high, the error flag is set. The flag stays set until reset,
    // and it never changes how the FSM behaves.
    // ------------------------------------------------------------------
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             err_q;

    // Next counter value: clear on entry to ACK, count while in ACK, saturate.
    always_comb begin
        cnt_d = cnt_q;
        if ((state_q == ST_VALID) && sync_ready) begin
            cnt_d = '0;
        end else if ((state_q == ST_ACK) && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Register the counter and the sticky timeout flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if ((state_q == ST_ACK) && req_s && (cnt_q == CNT_MAX)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign timeout_err = err_q;
`endif

endmodule
